// File: rtl/fc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fc_alu_sequencer
// Brief    : Sequences one fully-connected layer pass through an external
//            INPUT_SZ-lane multiply-accumulate ALU. Each neuron is processed
//            as CLEAR, then NUM_CHUNKS x (FETCH, LOAD_W, LOAD_X, CAPTURE),
//            then OUTPUT with a valid/ready handshake.
//            Optional macro FC_SEQ_RELU_EN clamps negative final sums to 0.
// Revision : 1.0 - initial release
// ============================================================================
module fc_alu_sequencer #(
    parameter int SIZE        = 16,
    parameter int PRECISION   = 11,
    parameter int INPUT_SZ    = 4,
    parameter int NUM_CHUNKS  = 4,
    parameter int NUM_NEURONS = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        w_rd_en,
    output logic [$clog2(NUM_NEURONS*NUM_CHUNKS)-1:0]   w_addr,
    input  logic [SIZE*INPUT_SZ-1:0]                    w_rd_data,
    output logic                                        x_rd_en,
    output logic [$clog2(NUM_CHUNKS)-1:0]               x_addr,
    input  logic [SIZE*INPUT_SZ-1:0]                    x_rd_data,
    output logic                                        b_rd_en,
    output logic [$clog2(NUM_NEURONS)-1:0]              b_addr,
    input  logic [SIZE-1:0]                             b_rd_data,
    output logic [SIZE*INPUT_SZ-1:0]                    alu_values,
    output logic [SIZE-1:0]                             alu_single,
    output logic [1:0]                                  alu_load_enable,
    output logic                                        alu_clear,
    input  logic [SIZE-1:0]                             alu_value,
    output logic                                        out_valid,
    output logic [SIZE-1:0]                             out_data,
    output logic [$clog2(NUM_NEURONS)-1:0]              out_index,
    input  logic                                        out_ready
);

    localparam int c_WA_W = $clog2(NUM_NEURONS*NUM_CHUNKS);
    localparam int c_XA_W = $clog2(NUM_CHUNKS);
    localparam int c_NA_W = $clog2(NUM_NEURONS);

    localparam logic [c_XA_W-1:0] c_LAST_CHUNK  = c_XA_W'(NUM_CHUNKS - 1);
    localparam logic [c_NA_W-1:0] c_LAST_NEURON = c_NA_W'(NUM_NEURONS - 1);
    localparam logic [c_WA_W-1:0] c_CHUNKS_W    = c_WA_W'(NUM_CHUNKS);

    // ALU load-enable encoding: 0 loads x lanes, 1 loads weights + single, 2 holds
    localparam logic [1:0] c_ALU_LOAD_X = 2'd0;
    localparam logic [1:0] c_ALU_LOAD_W = 2'd1;
    localparam logic [1:0] c_ALU_HOLD   = 2'd2;

    // The fixed-point format is owned by the ALU; the sequencer only moves words.
    if (PRECISION < SIZE) begin : g_fraction_fits_word
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_FETCH   = 3'd2,
        S_LOAD_W  = 3'd3,
        S_LOAD_X  = 3'd4,
        S_CAPTURE = 3'd5,
        S_OUTPUT  = 3'd6
    } state_t;

    state_t              r_state,  w_state_nx;
    logic [c_NA_W-1:0]   r_neuron, w_neuron_nx;
    logic [c_XA_W-1:0]   r_chunk,  w_chunk_nx;

    logic                r_busy,      w_busy_nx;
    logic                r_done,      w_done_nx;
    logic                r_out_valid, w_out_valid_nx;
    logic                r_w_rd_en,   w_w_rd_en_nx;
    logic [c_WA_W-1:0]   r_w_addr,    w_w_addr_nx;
    logic                r_x_rd_en,   w_x_rd_en_nx;
    logic [c_XA_W-1:0]   r_x_addr,    w_x_addr_nx;
    logic                r_b_rd_en,   w_b_rd_en_nx;
    logic [c_NA_W-1:0]   r_b_addr,    w_b_addr_nx;
    logic [1:0]          r_alu_le,    w_alu_le_nx;
    logic                r_alu_clear, w_alu_clear_nx;

    logic [SIZE-1:0]          r_bias;
    logic [SIZE*INPUT_SZ-1:0] r_x;
    logic [SIZE-1:0]          r_sum;
    logic [SIZE-1:0]          r_out_data;
    logic [c_NA_W-1:0]        r_out_index;
    logic [SIZE-1:0]          w_result;

    // Next state, counters and Moore-style control decoded from the next state
    always_comb begin
        w_state_nx     = r_state;
        w_neuron_nx    = r_neuron;
        w_chunk_nx     = r_chunk;
        w_done_nx      = 1'b0;
        w_out_valid_nx = 1'b0;
        w_w_rd_en_nx   = 1'b0;
        w_w_addr_nx    = '0;
        w_x_rd_en_nx   = 1'b0;
        w_x_addr_nx    = '0;
        w_b_rd_en_nx   = 1'b0;
        w_b_addr_nx    = '0;
        w_alu_le_nx    = c_ALU_HOLD;
        w_alu_clear_nx = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nx  = S_CLEAR;
                    w_neuron_nx = '0;
                    w_chunk_nx  = '0;
                end
            end
            S_CLEAR:  w_state_nx = S_FETCH;
            S_FETCH:  w_state_nx = S_LOAD_W;
            S_LOAD_W: w_state_nx = S_LOAD_X;
            S_LOAD_X: w_state_nx = S_CAPTURE;
            S_CAPTURE: begin
                if (r_chunk != c_LAST_CHUNK) begin
                    w_chunk_nx = r_chunk + 1'b1;
                    w_state_nx = S_FETCH;
                end else begin
                    w_state_nx = S_OUTPUT;
                end
            end
            S_OUTPUT: begin
                if (out_ready) begin
                    if (r_neuron == c_LAST_NEURON) begin
                        w_state_nx = S_IDLE;
                        w_done_nx  = 1'b1;
                    end else begin
                        w_neuron_nx = r_neuron + 1'b1;
                        w_chunk_nx  = '0;
                        w_state_nx  = S_CLEAR;
                    end
                end
            end
            default: w_state_nx = S_IDLE;
        endcase

        case (w_state_nx)
            S_CLEAR: begin
                w_alu_clear_nx = 1'b1;
                w_b_rd_en_nx   = 1'b1;
                w_b_addr_nx    = w_neuron_nx;
            end
            S_FETCH: begin
                w_w_rd_en_nx = 1'b1;
                w_x_rd_en_nx = 1'b1;
                w_w_addr_nx  = c_WA_W'(w_neuron_nx) * c_CHUNKS_W + c_WA_W'(w_chunk_nx);
                w_x_addr_nx  = w_chunk_nx;
            end
            S_LOAD_W: w_alu_le_nx    = c_ALU_LOAD_W;
            S_LOAD_X: w_alu_le_nx    = c_ALU_LOAD_X;
            S_OUTPUT: w_out_valid_nx = 1'b1;
            default: ;
        endcase

        w_busy_nx = (w_state_nx != S_IDLE);
    end

    // State, counters and registered control outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_neuron    <= '0;
            r_chunk     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_out_valid <= 1'b0;
            r_w_rd_en   <= 1'b0;
            r_w_addr    <= '0;
            r_x_rd_en   <= 1'b0;
            r_x_addr    <= '0;
            r_b_rd_en   <= 1'b0;
            r_b_addr    <= '0;
            r_alu_le    <= c_ALU_HOLD;
            r_alu_clear <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_neuron    <= w_neuron_nx;
            r_chunk     <= w_chunk_nx;
            r_busy      <= w_busy_nx;
            r_done      <= w_done_nx;
            r_out_valid <= w_out_valid_nx;
            r_w_rd_en   <= w_w_rd_en_nx;
            r_w_addr    <= w_w_addr_nx;
            r_x_rd_en   <= w_x_rd_en_nx;
            r_x_addr    <= w_x_addr_nx;
            r_b_rd_en   <= w_b_rd_en_nx;
            r_b_addr    <= w_b_addr_nx;
            r_alu_le    <= w_alu_le_nx;
            r_alu_clear <= w_alu_clear_nx;
        end
    end

    // Final-sum shaping; intermediate chunk sums are never clamped
    always_comb begin
`ifdef FC_SEQ_RELU_EN
        w_result = alu_value[SIZE-1] ? '0 : alu_value;
`else
        w_result = alu_value;
`endif
    end

    // Datapath captures: bias arrives in FETCH, x in LOAD_W, ALU sum in CAPTURE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bias      <= '0;
            r_x         <= '0;
            r_sum       <= '0;
            r_out_data  <= '0;
            r_out_index <= '0;
        end else begin
            if (r_state == S_FETCH && r_chunk == '0) begin
                r_bias <= b_rd_data;
            end
            if (r_state == S_LOAD_W) begin
                r_x <= x_rd_data;
            end
            if (r_state == S_CAPTURE) begin
                r_sum <= alu_value;
                if (r_chunk == c_LAST_CHUNK) begin
                    r_out_data  <= w_result;
                    r_out_index <= r_neuron;
                end
            end
        end
    end

    // ALU operand steering: weights straight from memory, x from its register
    always_comb begin
        alu_values = '0;
        alu_single = '0;
        case (r_state)
            S_LOAD_W: begin
                alu_values = w_rd_data;
                alu_single = (r_chunk == '0) ? r_bias : r_sum;
            end
            S_LOAD_X: alu_values = r_x;
            default: ;
        endcase
    end

    assign busy            = r_busy;
    assign done            = r_done;
    assign out_valid       = r_out_valid;
    assign out_data        = r_out_data;
    assign out_index       = r_out_index;
    assign w_rd_en         = r_w_rd_en;
    assign w_addr          = r_w_addr;
    assign x_rd_en         = r_x_rd_en;
    assign x_addr          = r_x_addr;
    assign b_rd_en         = r_b_rd_en;
    assign b_addr          = r_b_addr;
    assign alu_load_enable = r_alu_le;
    assign alu_clear       = r_alu_clear;

endmodule
`default_nettype wire

// File: tb/tb_fc_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_fc_alu_sequencer
// Brief    : Self-checking bench for fc_alu_sequencer with behavioural
//            memories, a behavioural Q-format ALU and a dot-product reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fc_alu_sequencer;

    localparam int SIZE = 16;
    localparam int PRECISION = 11;
    localparam int INPUT_SZ = 4;
    localparam int NC = 4;
    localparam int NN = 8;
    localparam int LW = SIZE * INPUT_SZ;
    localparam int WA_W = $clog2(NN*NC);
    localparam int XA_W = $clog2(NC);
    localparam int NA_W = $clog2(NN);

    logic clk = 1'b0;
    logic rst_n, start, out_ready;
    logic busy, done;
    logic w_rd_en, x_rd_en, b_rd_en;
    logic [WA_W-1:0] w_addr;
    logic [XA_W-1:0] x_addr;
    logic [NA_W-1:0] b_addr;
    logic [LW-1:0] w_rd_data, x_rd_data;
    logic [SIZE-1:0] b_rd_data;
    logic [LW-1:0] alu_values;
    logic [SIZE-1:0] alu_single, alu_value;
    logic [1:0] alu_load_enable;
    logic alu_clear;
    logic out_valid;
    logic [SIZE-1:0] out_data;
    logic [NA_W-1:0] out_index;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fc_alu_sequencer #(
        .SIZE(SIZE), .PRECISION(PRECISION), .INPUT_SZ(INPUT_SZ),
        .NUM_CHUNKS(NC), .NUM_NEURONS(NN)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .w_rd_en(w_rd_en), .w_addr(w_addr), .w_rd_data(w_rd_data),
        .x_rd_en(x_rd_en), .x_addr(x_addr), .x_rd_data(x_rd_data),
        .b_rd_en(b_rd_en), .b_addr(b_addr), .b_rd_data(b_rd_data),
        .alu_values(alu_values), .alu_single(alu_single),
        .alu_load_enable(alu_load_enable), .alu_clear(alu_clear),
        .alu_value(alu_value),
        .out_valid(out_valid), .out_data(out_data), .out_index(out_index),
        .out_ready(out_ready)
    );

    // Memories with one-cycle read latency
    logic [LW-1:0]   w_mem [NN*NC];
    logic [LW-1:0]   x_mem [NC];
    logic [SIZE-1:0] b_mem [NN];

    always_ff @(posedge clk) begin
        if (w_rd_en) w_rd_data <= w_mem[w_addr];
        if (x_rd_en) x_rd_data <= x_mem[x_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_addr];
    end

    // Signed fixed-point multiply, truncated back to one word
    function automatic logic [SIZE-1:0] qmul(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b);
        logic signed [2*SIZE-1:0] p;
        p = $signed(a) * $signed(b);
        return SIZE'(p >>> PRECISION);
    endfunction

    // Behavioural ALU: lane registers plus a single accumulator operand
    logic [SIZE-1:0] alu_w [INPUT_SZ];
    logic [SIZE-1:0] alu_x [INPUT_SZ];
    logic [SIZE-1:0] alu_s;

    always_ff @(posedge clk) begin
        for (int i = 0; i < INPUT_SZ; i++) begin
            if (alu_clear) begin
                alu_w[i] <= '0;
                alu_x[i] <= '0;
            end else if (alu_load_enable == 2'd1) begin
                alu_w[i] <= alu_values[i*SIZE +: SIZE];
            end else if (alu_load_enable == 2'd0) begin
                alu_x[i] <= alu_values[i*SIZE +: SIZE];
            end
        end
        if (alu_clear) alu_s <= '0;
        else if (alu_load_enable == 2'd1) alu_s <= alu_single;
    end

    always_comb begin
        alu_value = alu_s;
        for (int i = 0; i < INPUT_SZ; i++) alu_value = alu_value + qmul(alu_w[i], alu_x[i]);
    end

    // Reference: bias plus the whole dot product, wrapped to one word
    function automatic logic [SIZE-1:0] ref_out(input int n);
        logic [SIZE-1:0] acc;
        logic [LW-1:0] wv, xv;
        acc = b_mem[n];
        for (int c = 0; c < NC; c++) begin
            wv = w_mem[n*NC + c];
            xv = x_mem[c];
            for (int i = 0; i < INPUT_SZ; i++) acc = acc + qmul(wv[i*SIZE +: SIZE], xv[i*SIZE +: SIZE]);
        end
`ifdef FC_SEQ_RELU_EN
        if (acc[SIZE-1]) acc = '0;
`endif
        return acc;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: all ones (1.0); 1: zero weights, ramp bias; 2: random; 3: zero weights, bias -1.0
    task automatic fill(input int mode);
        for (int c = 0; c < NC; c++)
            x_mem[c] = (mode == 0) ? {INPUT_SZ{16'h0800}} : {$urandom, $urandom};
        for (int n = 0; n < NN; n++) begin
            case (mode)
                0: b_mem[n] = 16'h0000;
                1: b_mem[n] = 16'(16'h0100 * n);
                2: b_mem[n] = 16'($urandom);
                default: b_mem[n] = 16'hF800;
            endcase
            for (int c = 0; c < NC; c++)
                w_mem[n*NC + c] = (mode == 0) ? {INPUT_SZ{16'h0800}} :
                                  (mode == 2) ? {$urandom, $urandom} : '0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_ctl"}, {busy, done, out_valid, w_rd_en, x_rd_en, b_rd_en, alu_clear, alu_load_enable},
              9'b000_000_1_10);
        check({tag, "_data"}, {out_data, out_index, w_addr, x_addr, b_addr}, '0);
        check({tag, "_alu"}, {alu_values, alu_single}, '0);
    endtask

    // One layer pass; optional stall on a neuron, mid-pass start, or early abort
    task automatic run_pass(input int stall_n, input int stall_cyc, input int restart_at,
                            input int abort_at, output int cycles);
        int got, stall;
        bit aborted;
        logic [SIZE-1:0] held_d;
        logic [NA_W-1:0] held_i;
        got = 0; stall = 0; aborted = 0; held_d = '0; held_i = '0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cycles = 0;
        check("busy_after_start", busy, 1);
        while (!done && cycles < 2000 && !aborted) begin
            if (abort_at > 0 && cycles == abort_at) begin
                aborted = 1;
            end else begin
                start = (cycles == restart_at);
                if (stall > 0 && stall < stall_cyc) begin
                    check("stall_valid", out_valid, 1);
                    check("stall_data", out_data, held_d);
                    check("stall_index", out_index, held_i);
                    out_ready = 1'b0;
                    stall++;
                end else if (out_valid) begin
                    if (got == stall_n && stall == 0 && stall_cyc > 0) begin
                        held_d = out_data;
                        held_i = out_index;
                        out_ready = 1'b0;
                        stall = 1;
                    end else begin
                        check("out_index", out_index, got);
                        check("out_data", out_data, ref_out(got));
                        out_ready = 1'b1;
                        got++;
                    end
                end else begin
                    out_ready = 1'b0;
                end
                @(negedge clk);
                cycles++;
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (!aborted) begin
            check("done_pulse", done, 1);
            check("neurons_out", got, NN);
            check("busy_at_done", busy, 0);
            @(negedge clk);
            check("done_one_cycle", done, 0);
        end
    endtask

    int cyc_nom, cyc_tmp;

    initial begin
        rst_n = 1'b0; start = 1'b0; out_ready = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        check_reset_values("por");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_busy", busy, 0);

        // 16 lanes of 1.0*1.0 per neuron, wrapped in a 16-bit word
        run_pass(-1, 0, -1, 0, cyc_nom);
        // CLEAR + 4 steps per chunk, plus one OUTPUT handshake cycle, per neuron
        check("cycles_nominal", cyc_nom, NN * (1 + 4*NC) + NN);

        fill(1);
        run_pass(-1, 0, -1, 0, cyc_tmp);

        fill(2);
        run_pass(2, 5, -1, 0, cyc_tmp);
        check("cycles_stall", cyc_tmp, cyc_nom + 5);

        fill(2);
        run_pass(-1, 0, 20, 0, cyc_tmp);
        check("cycles_restart", cyc_tmp, cyc_nom);

        // Neuron 3 starts at cycle 54; its chunk 2 spans cycles 63..66
        fill(2);
        run_pass(-1, 0, -1, 64, cyc_tmp);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("post_abort_idle", {busy, done, out_valid}, 3'b000);
        run_pass(-1, 0, -1, 0, cyc_tmp);

        fill(3);
        run_pass(-1, 0, -1, 0, cyc_tmp);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
